// File: rtl/rst_seq_pkg.sv
// Shared types, default constants and helper functions for the staged
// reset/teardown controller and its timer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RELEASE    = 3'd0,
    UP         = 3'd1,
    DRAIN_WAIT = 3'd2,
    DRAIN_GAP  = 3'd3,
    DOWN       = 3'd4
  } state_t;

  localparam int unsigned DEF_N_STAGES    = 4;
  localparam int unsigned DEF_CNT_W       = 23;
  localparam logic [22:0] DEF_REL_FIRST   = 23'h1FFFFF;
  localparam logic [22:0] DEF_REL_STEP    = 23'h100000;
  localparam logic [15:0] DEF_ACK_TIMEOUT = 16'hFFFF;
  localparam logic [7:0]  DEF_GAP_CYC     = 8'd16;

  localparam int unsigned TMR_W = 16;

  // Computed in 64 bits so the caller can detect a threshold overflowing CNT_W.
  function automatic longint unsigned rel_threshold(
    input longint unsigned first,
    input longint unsigned step,
    input longint unsigned k
  );
    return first + step * k;
  endfunction

  // The timer flags done once it reaches zero, so a wait of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] tmr_load(input logic [TMR_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 1'b1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter; o_done is high for one cycle when the count reaches
// zero after a load. Shared between the quiesce-ack timeout and the drain gap.
module rst_seq_timer
  import rst_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_val,
  output logic             o_done
);

  logic [TMR_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/reset_teardown_seq.sv
// Bidirectional staged reset controller: ascending release after reset, ordered
// descending drain on iSHDN_REQ. Define RST_SEQ_STATUS_EN for oSTATE/oTO_FLAGS.
module reset_teardown_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned      N_STAGES    = DEF_N_STAGES,
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] REL_FIRST   = DEF_REL_FIRST,
  parameter logic [CNT_W-1:0] REL_STEP    = DEF_REL_STEP,
  parameter logic [15:0]      ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter logic [7:0]       GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSHDN_REQ,
  input  logic [N_STAGES-1:0] iQUIESCE_ACK,
  output logic [N_STAGES-1:0] oRST,
  output logic [N_STAGES-1:0] oQUIESCE_REQ,
  output logic                oUP,
  output logic                oSHDN_DONE
`ifdef RST_SEQ_STATUS_EN
  ,
  output logic [2:0]          oSTATE,
  output logic [N_STAGES-1:0] oTO_FLAGS
`endif
);

  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam longint unsigned LAST_THR_L =
    rel_threshold(64'(REL_FIRST), 64'(REL_STEP), 64'(N_STAGES - 1));
  localparam logic [CNT_W-1:0] CNT_MAX  = LAST_THR_L[CNT_W-1:0];
  localparam logic [TMR_W-1:0] ACK_LOAD = tmr_load(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] GAP_LOAD = tmr_load(TMR_W'(GAP_CYC));

  if ((LAST_THR_L >> CNT_W) != 64'd0) begin : g_thr_overflow
    $error("reset_teardown_seq: last release threshold does not fit in CNT_W bits");
  end

  state_t              r_state, w_state_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next, w_top_rel;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_STAGES-1:0] r_hit, r_rst, w_hit, w_req;
  logic                w_tmr_load, w_tmr_done, w_ack, w_wait_exit, w_restart;
  logic [TMR_W-1:0]    w_tmr_val;

  // r_hit delays the threshold compare so a stage releases the edge after its hit.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    localparam longint unsigned THR_L =
      rel_threshold(64'(REL_FIRST), 64'(REL_STEP), 64'(gi));
    localparam logic [CNT_W-1:0] THR = THR_L[CNT_W-1:0];
    assign w_hit[gi] = (r_cnt >= THR);
    assign w_req[gi] = (r_state == DRAIN_WAIT) && (r_idx == IDX_W'(gi));
  end

  always_comb begin
    w_top_rel = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (r_rst[k]) w_top_rel = IDX_W'(k);
    end
  end

  assign w_ack       = iQUIESCE_ACK[r_idx];
  assign w_wait_exit = (r_state == DRAIN_WAIT) && (w_ack || w_tmr_done);
  assign w_restart   = (r_state == DOWN) && !iSHDN_REQ;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      RELEASE, UP: begin
        if (iSHDN_REQ) begin
          if (|r_rst) begin
            w_state_next = DRAIN_WAIT;
            w_idx_next   = w_top_rel;
          end else begin
            w_state_next = DOWN;
          end
        end else if ((r_state == RELEASE) && r_rst[N_STAGES-1]) begin
          w_state_next = UP;
        end
      end
      DRAIN_WAIT: begin
        if (w_wait_exit) w_state_next = (r_idx == '0) ? DOWN : DRAIN_GAP;
      end
      DRAIN_GAP: begin
        if (w_tmr_done) begin
          w_state_next = DRAIN_WAIT;
          w_idx_next   = r_idx - 1'b1;
        end
      end
      DOWN: begin
        if (!iSHDN_REQ) w_state_next = RELEASE;
      end
      default: w_state_next = RELEASE;
    endcase
  end

  // The timer is (re)loaded on every entry to a wait state.
  assign w_tmr_load = (w_state_next != r_state) &&
                      ((w_state_next == DRAIN_WAIT) || (w_state_next == DRAIN_GAP));
  assign w_tmr_val  = (w_state_next == DRAIN_WAIT) ? ACK_LOAD : GAP_LOAD;

  rst_seq_timer u_timer (
    .i_clk  (iCLK),
    .i_srst (iRST),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= RELEASE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_hit   <= '0;
      r_rst   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (r_state == RELEASE) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        r_hit <= w_hit;
        if (w_state_next == RELEASE) r_rst <= r_rst | r_hit;
      end
      if (w_restart) begin
        r_cnt <= '0;
        r_hit <= '0;
      end
      if (w_wait_exit) r_rst[r_idx] <= 1'b0;
    end
  end

  assign oRST         = r_rst;
  assign oQUIESCE_REQ = w_req;
  assign oUP          = (r_state == UP);
  assign oSHDN_DONE   = (r_state == DOWN);

`ifdef RST_SEQ_STATUS_EN
  logic [N_STAGES-1:0] r_to_flags;

  always_ff @(posedge iCLK) begin
    if (iRST || w_restart) r_to_flags <= '0;
    else if (w_wait_exit && !w_ack) r_to_flags[r_idx] <= 1'b1;
  end

  assign oSTATE    = r_state;
  assign oTO_FLAGS = r_to_flags;
`endif

endmodule
